// File: rtl/wt_dcache_ship_predictor_pkg.sv
// Shared constants, line metadata type and PC signature hash for the
// dcache SHiP reuse predictor.
package wt_dcache_ship_predictor_pkg;

   // Cache geometry
   localparam int unsigned DCACHE_SET_ASSOC    = 4;
   localparam int unsigned DCACHE_CL_IDX_WIDTH = 6;
   localparam int unsigned DCACHE_NUM_WORDS    = 2 ** DCACHE_CL_IDX_WIDTH;

   // Predictor sizing
   localparam int unsigned SHIP_PC_WIDTH  = 64;
   localparam int unsigned SHIP_SIG_WIDTH = 8;
   localparam int unsigned SHIP_CTR_WIDTH = 2;
   localparam int unsigned SHIP_CTR_INIT  = 1;

   // PC[63:2] is folded in SIG-wide chunks; the last chunk is zero-padded
   localparam int unsigned SHIP_FOLD_WIDTH = SHIP_PC_WIDTH - 2;
   localparam int unsigned SHIP_NUM_CHUNKS = (SHIP_FOLD_WIDTH + SHIP_SIG_WIDTH - 1) / SHIP_SIG_WIDTH;
   localparam int unsigned SHIP_PAD_WIDTH  = SHIP_NUM_CHUNKS * SHIP_SIG_WIDTH;

   // Per-line training state
   typedef struct packed {
      logic                      valid;
      logic                      outcome;
      logic [SHIP_SIG_WIDTH-1:0] sig;
   } ship_meta_t;

   // XOR-fold of the word-aligned PC into a signature
   function automatic logic [SHIP_SIG_WIDTH-1:0] ship_sig(input logic [SHIP_PC_WIDTH-1:0] pc);
      logic [SHIP_PAD_WIDTH-1:0] padded;
      logic [SHIP_SIG_WIDTH-1:0] sig;
      padded = SHIP_PAD_WIDTH'(pc[SHIP_PC_WIDTH-1:2]);
      sig    = '0;
      for (int i = 0; i < int'(SHIP_NUM_CHUNKS); i++) begin
         sig = sig ^ padded[i*SHIP_SIG_WIDTH +: SHIP_SIG_WIDTH];
      end
      return sig;
   endfunction

endpackage

// File: rtl/wt_dcache_ship_predictor_shct.sv
// Signature History Counter Table: saturating counters with one combinational
// read port and independent increment / decrement update ports.
// Ports: clk_i, rst_ni (async, active-low); rd_idx -> rd_data_c (comb read);
//        inc_en/inc_idx and dec_en/dec_idx apply at the clock edge.
module wt_dcache_ship_predictor_shct
   import wt_dcache_ship_predictor_pkg::*;
#(
   parameter int unsigned SIG_WIDTH = SHIP_SIG_WIDTH,
   parameter int unsigned CTR_WIDTH = SHIP_CTR_WIDTH,
   parameter int unsigned CTR_INIT  = SHIP_CTR_INIT
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [SIG_WIDTH-1:0] rd_idx,
   output logic [CTR_WIDTH-1:0] rd_data_c,
   input  logic                 inc_en,
   input  logic [SIG_WIDTH-1:0] inc_idx,
   input  logic                 dec_en,
   input  logic [SIG_WIDTH-1:0] dec_idx
);

   localparam int unsigned NUM_ENTRIES = 2 ** SIG_WIDTH;
   localparam logic [CTR_WIDTH-1:0] CTR_MAX = '1;
   localparam logic [CTR_WIDTH-1:0] CTR_ONE = CTR_WIDTH'(1);

   logic [CTR_WIDTH-1:0]   shct [NUM_ENTRIES];
   logic [NUM_ENTRIES-1:0] inc_sel;
   logic [NUM_ENTRIES-1:0] dec_sel;

   assign rd_data_c = shct[rd_idx];

   // One-hot entry selects for the two update ports
   always_comb begin
      inc_sel = '0;
      dec_sel = '0;
      if (inc_en) inc_sel[inc_idx] = 1'b1;
      if (dec_en) dec_sel[dec_idx] = 1'b1;
   end

   // Saturating update; inc and dec on the same entry cancel out
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
            shct[i] <= CTR_WIDTH'(CTR_INIT);
         end
      end else begin
         for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
            if (inc_sel[i] && !dec_sel[i] && (shct[i] != CTR_MAX)) begin
               shct[i] <= shct[i] + CTR_ONE;
            end else if (dec_sel[i] && !inc_sel[i] && (shct[i] != '0)) begin
               shct[i] <= shct[i] - CTR_ONE;
            end
         end
      end
   end

endmodule

// File: rtl/wt_dcache_ship_predictor.sv
// SHiP reuse predictor for the write-through L1 dcache. Returns a registered
// SHCT prediction one cycle after each line allocation and trains the SHCT
// from first re-references (hits) and evictions of never-reused lines.
// Ports: clk_i, rst_ni (async, active-low), flush_i (drops line metadata);
//        pred_req_i/pred_pc_i/pred_idx_i/pred_way_i: allocation request;
//        pred_valid_o/pred_result_o: prediction, one cycle later;
//        hit_i/hit_idx_i/hit_way_i: cache hit notification.
module wt_dcache_ship_predictor
   import wt_dcache_ship_predictor_pkg::*;
#(
   parameter int unsigned PC_WIDTH  = SHIP_PC_WIDTH,
   parameter int unsigned SIG_WIDTH = SHIP_SIG_WIDTH,
   parameter int unsigned CTR_WIDTH = SHIP_CTR_WIDTH,
   parameter int unsigned CTR_INIT  = SHIP_CTR_INIT,
   parameter int unsigned NUM_SETS  = DCACHE_NUM_WORDS,
   parameter int unsigned NUM_WAYS  = DCACHE_SET_ASSOC
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic                           flush_i,
   input  logic                           pred_req_i,
   input  logic [PC_WIDTH-1:0]            pred_pc_i,
   input  logic [DCACHE_CL_IDX_WIDTH-1:0] pred_idx_i,
   input  logic [$clog2(NUM_WAYS)-1:0]    pred_way_i,
   output logic                           pred_valid_o,
   output logic [CTR_WIDTH-1:0]           pred_result_o,
   input  logic                           hit_i,
   input  logic [DCACHE_CL_IDX_WIDTH-1:0] hit_idx_i,
   input  logic [$clog2(NUM_WAYS)-1:0]    hit_way_i
);

   ship_meta_t meta [NUM_SETS][NUM_WAYS];

   logic                      req_ok;
   logic                      hit_ok;
   logic [SHIP_SIG_WIDTH-1:0] req_sig;
   ship_meta_t                old_meta;
   ship_meta_t                hit_meta;
   logic                      inc_en;
   logic                      dec_en;
   logic [CTR_WIDTH-1:0]      rd_data_c;

   // Event qualification: flush swallows everything, a request to the same
   // line overrides the hit
   always_comb begin
      req_ok   = pred_req_i && !flush_i;
      hit_ok   = hit_i && !flush_i &&
                 !(req_ok && (hit_idx_i == pred_idx_i) && (hit_way_i == pred_way_i));
      req_sig  = ship_sig(SHIP_PC_WIDTH'(pred_pc_i));
      old_meta = meta[pred_idx_i][pred_way_i];
      hit_meta = meta[hit_idx_i][hit_way_i];
      dec_en   = req_ok && old_meta.valid && !old_meta.outcome;
      inc_en   = hit_ok && hit_meta.valid && !hit_meta.outcome;
   end

   wt_dcache_ship_predictor_shct #(
      .SIG_WIDTH (SIG_WIDTH),
      .CTR_WIDTH (CTR_WIDTH),
      .CTR_INIT  (CTR_INIT)
   ) i_shct (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .rd_idx    (SIG_WIDTH'(req_sig)),
      .rd_data_c (rd_data_c),
      .inc_en    (inc_en),
      .inc_idx   (SIG_WIDTH'(hit_meta.sig)),
      .dec_en    (dec_en),
      .dec_idx   (SIG_WIDTH'(old_meta.sig))
   );

   // Line metadata; a request and a qualified hit never address the same line
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int s = 0; s < int'(NUM_SETS); s++) begin
            for (int w = 0; w < int'(NUM_WAYS); w++) begin
               meta[s][w] <= '0;
            end
         end
      end else if (flush_i) begin
         for (int s = 0; s < int'(NUM_SETS); s++) begin
            for (int w = 0; w < int'(NUM_WAYS); w++) begin
               meta[s][w].valid <= 1'b0;
            end
         end
      end else begin
         if (req_ok) begin
            meta[pred_idx_i][pred_way_i] <= '{valid: 1'b1, outcome: 1'b0, sig: req_sig};
         end
         if (inc_en) begin
            meta[hit_idx_i][hit_way_i].outcome <= 1'b1;
         end
      end
   end

   // Prediction output register (SHCT value before this cycle's updates)
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pred_valid_o  <= 1'b0;
         pred_result_o <= '0;
      end else begin
         pred_valid_o <= req_ok;
         if (req_ok) pred_result_o <= rd_data_c;
      end
   end

endmodule

// File: tb/tb_wt_dcache_ship_predictor.sv
// Scoreboard bench for the SHiP predictor: stimulus pushes hand-computed
// predictions, a negedge monitor pops and checks value and latency.
// PCs below 0x400 have signature pc[9:2]; 0x80000100 folds to 0x60.
module tb_wt_dcache_ship_predictor;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        flush_i;
   logic        pred_req_i;
   logic [63:0] pred_pc_i;
   logic [5:0]  pred_idx_i;
   logic [1:0]  pred_way_i;
   logic        pred_valid_o;
   logic [1:0]  pred_result_o;
   logic        hit_i;
   logic [5:0]  hit_idx_i;
   logic [1:0]  hit_way_i;

   typedef struct {
      logic [1:0] res;
      int         cyc;
   } exp_t;

   exp_t sb_q[$];
   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;

   wt_dcache_ship_predictor dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .flush_i       (flush_i),
      .pred_req_i    (pred_req_i),
      .pred_pc_i     (pred_pc_i),
      .pred_idx_i    (pred_idx_i),
      .pred_way_i    (pred_way_i),
      .pred_valid_o  (pred_valid_o),
      .pred_result_o (pred_result_o),
      .hit_i         (hit_i),
      .hit_idx_i     (hit_idx_i),
      .hit_way_i     (hit_way_i)
   );

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;

   // Monitor: every valid pulse must match the oldest expectation, one cycle late
   always @(negedge clk_i) begin
      if (rst_ni && pred_valid_o) begin
         exp_t e;
         vectors++;
         if (sb_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_pred: pred_valid_o=1 result=%0d with nothing expected (cycle %0d)",
                     pred_result_o, cyc);
         end else begin
            e = sb_q.pop_front();
            if (pred_result_o !== e.res || cyc != e.cyc + 1) begin
               miscompares++;
               $display("FAIL pred_result: got %0d at cycle %0d, expected %0d at cycle %0d",
                        pred_result_o, cyc, e.res, e.cyc + 1);
            end
         end
      end
   end

   task automatic check(input string name, input logic [1:0] got, input logic [1:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", name, got, want);
      end
   endtask

   // One clock of stimulus; inputs are applied just after a rising edge
   task automatic drive(input logic req, input logic [63:0] pc, input logic [5:0] idx,
                        input logic [1:0] way, input logic hit, input logic [5:0] hidx,
                        input logic [1:0] hway, input logic flush, input logic push,
                        input logic [1:0] res);
      pred_req_i = req;
      pred_pc_i  = pc;
      pred_idx_i = idx;
      pred_way_i = way;
      hit_i      = hit;
      hit_idx_i  = hidx;
      hit_way_i  = hway;
      flush_i    = flush;
      if (push) sb_q.push_back('{res: res, cyc: cyc});
      @(posedge clk_i);
      #1;
      pred_req_i = 1'b0;
      hit_i      = 1'b0;
      flush_i    = 1'b0;
   endtask

   task automatic req(input logic [63:0] pc, input logic [5:0] idx, input logic [1:0] way,
                      input logic [1:0] res);
      drive(1'b1, pc, idx, way, 1'b0, 6'd0, 2'd0, 1'b0, 1'b1, res);
   endtask

   task automatic hit(input logic [5:0] idx, input logic [1:0] way);
      drive(1'b0, 64'd0, 6'd0, 2'd0, 1'b1, idx, way, 1'b0, 1'b0, 2'd0);
   endtask

   initial begin
      int budget;
      rst_ni     = 1'b0;
      flush_i    = 1'b0;
      pred_req_i = 1'b0;
      pred_pc_i  = '0;
      pred_idx_i = '0;
      pred_way_i = '0;
      hit_i      = 1'b0;
      hit_idx_i  = '0;
      hit_way_i  = '0;
      repeat (3) @(posedge clk_i);
      #1;
      check("reset_valid", {1'b0, pred_valid_o}, 2'd0);
      check("reset_result", pred_result_o, 2'd0);
      rst_ni = 1'b1;

      // First request after reset: SHCT at init value
      req(64'h8000_0100, 6'd3, 2'd0, 2'd1);

      // Reuse training: only the first hit counts (sig 0x05)
      req(64'h14, 6'd5, 2'd2, 2'd1);
      hit(6'd5, 2'd2);
      hit(6'd5, 2'd2);
      hit(6'd5, 2'd2);
      req(64'h14, 6'd9, 2'd0, 2'd2);

      // Eviction without reuse, saturating at 0 (sig 0x07 vs 0x08)
      req(64'h1C, 6'd7, 2'd1, 2'd1);
      req(64'h20, 6'd7, 2'd1, 2'd1);
      req(64'h1C, 6'd7, 2'd1, 2'd0);
      req(64'h20, 6'd7, 2'd1, 2'd0);
      req(64'h1C, 6'd10, 2'd0, 2'd0);

      // Same-cycle inc and dec of sig 0x0A cancel
      req(64'h28, 6'd11, 2'd0, 2'd1);
      req(64'h28, 6'd11, 2'd1, 2'd1);
      drive(1'b1, 64'h2C, 6'd11, 2'd1, 1'b1, 6'd11, 2'd0, 1'b0, 1'b1, 2'd1);
      req(64'h28, 6'd12, 2'd0, 2'd1);

      // Hit and request on the same line: request wins (sig 0x0C -> 0x0D)
      req(64'h30, 6'd2, 2'd3, 2'd1);
      drive(1'b1, 64'h34, 6'd2, 2'd3, 1'b1, 6'd2, 2'd3, 1'b0, 1'b1, 2'd1);
      hit(6'd2, 2'd3);
      req(64'h30, 6'd13, 2'd0, 2'd0);
      req(64'h34, 6'd13, 2'd1, 2'd2);

      // Saturation at the top (sig 0x0E), no wrap
      req(64'h38, 6'd4, 2'd0, 2'd1);
      hit(6'd4, 2'd0);
      req(64'h38, 6'd4, 2'd0, 2'd2);
      hit(6'd4, 2'd0);
      req(64'h38, 6'd4, 2'd0, 2'd3);
      hit(6'd4, 2'd0);
      req(64'h38, 6'd4, 2'd0, 2'd3);
      hit(6'd4, 2'd0);
      req(64'h38, 6'd14, 2'd0, 2'd3);

      // Flush: request in the flush cycle dropped, later hit on old line ignored
      drive(1'b1, 64'h34, 6'd15, 2'd0, 1'b0, 6'd0, 2'd0, 1'b1, 1'b0, 2'd0);
      hit(6'd13, 2'd1);
      req(64'h34, 6'd15, 2'd0, 2'd2);

      // Asynchronous reset kills a pending prediction and restores the SHCT
      drive(1'b1, 64'h38, 6'd14, 2'd1, 1'b0, 6'd0, 2'd0, 1'b0, 1'b0, 2'd0);
      rst_ni = 1'b0;
      #1;
      check("async_reset_valid", {1'b0, pred_valid_o}, 2'd0);
      check("async_reset_result", pred_result_o, 2'd0);
      repeat (2) @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      req(64'h38, 6'd4, 2'd0, 2'd1);

      // Drain with a bounded wait
      budget = 20;
      while (sb_q.size() != 0 && budget > 0) begin
         @(posedge clk_i);
         budget--;
      end
      repeat (2) @(posedge clk_i);
      if (sb_q.size() != 0) begin
         vectors++;
         miscompares++;
         $display("FAIL drain: %0d predictions never seen, expected 0", sb_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
